// File: rtl/qcore_hz_pkg.sv
// Shared types and constants for the qcore hazard / forwarding logic.
package qcore_hz_pkg;

   localparam int unsigned QC_DW = 32;
   localparam int unsigned QC_AW = 7;

   // Where a resolved operand value comes from
   typedef enum logic [1:0] {
      SRC_ZERO,
      SRC_LQ,
      SRC_STG,
      SRC_RF
   } fwd_src_t;

   // Width of a counter that must be able to hold the value tmo
   function automatic int unsigned tmo_cnt_w(input int unsigned tmo);
      return ($clog2(tmo + 1) < 1) ? 1 : $clog2(tmo + 1);
   endfunction

endpackage

// File: rtl/qcore_sb_table.sv
// Pending-bit scoreboard for long-latency register writes.
module qcore_sb_table
   import qcore_hz_pkg::*;
#(
   parameter int unsigned AW       = QC_AW,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_issue,
   input  logic [AW-1:0]        i_issue_addr,
   input  logic                 i_done,
   input  logic [AW-1:0]        i_done_addr,
   output logic [(1<<AW)-1:0]   o_pend,
   output logic [AW:0]          o_pend_cnt,
   output logic                 o_sb_err
);

   logic [(1<<AW)-1:0] r_pend;
   logic [AW:0]        r_cnt;
   logic               r_err;

   logic w_iss_ok;
   logic w_done_ok;
   logic w_iss_hit;
   logic w_inc;
   logic w_dec;

   // Qualify issue/done and derive the population-count delta
   always_comb begin
      w_iss_ok  = i_issue && !(ZERO_REG && (i_issue_addr == '0));
      w_done_ok = i_done  && !(ZERO_REG && (i_done_addr  == '0));
      w_iss_hit = w_iss_ok && r_pend[i_issue_addr];
      w_inc     = w_iss_ok && !r_pend[i_issue_addr];
      // a done colliding with an issue on the same entry leaves it set
      w_dec     = w_done_ok && r_pend[i_done_addr] &&
                  !(w_iss_ok && (i_issue_addr == i_done_addr));
   end

   // Pending bits, incremental count and sticky double-issue error
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pend <= '0;
         r_cnt  <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_done_ok) r_pend[i_done_addr]  <= 1'b0;
         if (w_iss_ok)  r_pend[i_issue_addr] <= 1'b1;
         if (w_inc && !w_dec)      r_cnt <= r_cnt + 1'b1;
         else if (w_dec && !w_inc) r_cnt <= r_cnt - 1'b1;
         if (w_iss_hit) r_err <= 1'b1;
      end
   end

   assign o_pend     = r_pend;
   assign o_pend_cnt = r_cnt;
   assign o_sb_err   = r_err;

endmodule

// File: rtl/qcore_fwd_sb.sv
// Operand forwarding and hazard detection with long-latency scoreboard.
module qcore_fwd_sb
   import qcore_hz_pkg::*;
#(
   parameter int unsigned NRD      = 3,
   parameter int unsigned NSTG     = 3,
   parameter int unsigned DW       = QC_DW,
   parameter int unsigned AW       = QC_AW,
   parameter bit          ZERO_REG = 1'b1,
   parameter int unsigned TMO_CYC  = 1024
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NRD-1:0]      rs_vld_i,
   input  logic [NRD*AW-1:0]   rs_addr_i,
   input  logic [NRD*DW-1:0]   rs_dt_i,
   input  logic [NSTG-1:0]     stg_we_i,
   input  logic [NSTG*AW-1:0]  stg_addr_i,
   input  logic [NSTG-1:0]     stg_rdy_i,
   input  logic [NSTG*DW-1:0]  stg_dt_i,
   input  logic                lq_issue_i,
   input  logic [AW-1:0]       lq_addr_i,
   input  logic                lq_done_i,
   input  logic [AW-1:0]       lq_done_addr_i,
   input  logic [DW-1:0]       lq_done_dt_i,
   input  logic                hold_i,
   output logic [NRD*DW-1:0]   rs_dt_o,
   output logic                bubble_o,
   output logic [AW:0]         pend_cnt_o,
   output logic                sb_err_o,
   output logic                timeout_o
);

   localparam int unsigned     CW      = tmo_cnt_w(TMO_CYC);
   localparam logic [CW-1:0]   TMO_M1  = CW'(TMO_CYC - 1);
   localparam logic [CW-1:0]   TMO_MAX = CW'(TMO_CYC);

   logic [(1<<AW)-1:0] w_pend;
   logic [NRD*DW-1:0]  w_res;
   logic [NRD-1:0]     w_stall_v;
   logic               w_bubble;

   logic [NRD*DW-1:0]  r_dt;
   logic [CW-1:0]      r_tcnt;
   logic               r_tmo;

   qcore_sb_table #(
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .i_clk        (clk_i),
      .i_rst        (rst_i),
      .i_issue      (lq_issue_i),
      .i_issue_addr (lq_addr_i),
      .i_done       (lq_done_i),
      .i_done_addr  (lq_done_addr_i),
      .o_pend       (w_pend),
      .o_pend_cnt   (pend_cnt_o),
      .o_sb_err     (sb_err_o)
   );

   for (genvar gp = 0; gp < NRD; gp++) begin : g_port
      logic [AW-1:0] w_addr;
      logic          w_hit;
      logic          w_stg_stall;
      logic [DW-1:0] w_stg_dt;
      logic          w_stall;
      fwd_src_t      w_src;
      logic [DW-1:0] w_val;

      // Pick the source for this operand; youngest matching stage wins
      always_comb begin
         w_addr      = rs_addr_i[gp*AW +: AW];
         w_hit       = 1'b0;
         w_stg_stall = 1'b0;
         w_stg_dt    = '0;
         for (int unsigned s = 0; s < NSTG; s++) begin
            if (!w_hit && stg_we_i[s] && (stg_addr_i[s*AW +: AW] == w_addr)) begin
               w_hit       = 1'b1;
               w_stg_stall = !stg_rdy_i[s];
               w_stg_dt    = stg_dt_i[s*DW +: DW];
            end
         end
         w_src   = SRC_RF;
         w_stall = 1'b0;
         if (ZERO_REG && (w_addr == '0)) begin
            w_src = SRC_ZERO;
         end else if (lq_done_i && (lq_done_addr_i == w_addr)) begin
            w_src = SRC_LQ;
         end else if (w_pend[w_addr]) begin
            w_stall = 1'b1;
         end else if (w_hit) begin
            w_src   = SRC_STG;
            w_stall = w_stg_stall;
         end
      end

      // Operand value mux for the selected source
      always_comb begin
         case (w_src)
            SRC_ZERO: w_val = '0;
            SRC_LQ:   w_val = lq_done_dt_i;
            SRC_STG:  w_val = w_stg_dt;
            default:  w_val = rs_dt_i[gp*DW +: DW];
         endcase
      end

      assign w_res[gp*DW +: DW] = w_val;
      assign w_stall_v[gp]      = rs_vld_i[gp] & w_stall;
   end

   assign w_bubble = |w_stall_v;
   assign bubble_o = w_bubble;

   // Operand register, re-resolving every unfrozen cycle including bubbles
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_dt <= '0;
      end else if (!hold_i) begin
         r_dt <= w_res;
      end
   end

   // Consecutive-bubble counter, saturating, with sticky timeout flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_tcnt <= '0;
         r_tmo  <= 1'b0;
      end else if (!w_bubble) begin
         r_tcnt <= '0;
      end else begin
         if (r_tcnt != TMO_MAX) r_tcnt <= r_tcnt + 1'b1;
         if (r_tcnt == TMO_M1)  r_tmo  <= 1'b1;
      end
   end

   assign rs_dt_o   = r_dt;
   assign timeout_o = r_tmo;

endmodule

// File: tb/tb_qcore_fwd_sb.sv
// Scoreboard bench for qcore_fwd_sb: directed test-plan sequences then random traffic.
module tb_qcore_fwd_sb;

   localparam int TMO = 8;

   logic        clk;
   logic        rst;
   logic [2:0]  rs_vld;
   logic [20:0] rs_addr;
   logic [95:0] rs_dt;
   logic [2:0]  stg_we;
   logic [20:0] stg_addr;
   logic [2:0]  stg_rdy;
   logic [95:0] stg_dt;
   logic        lq_issue;
   logic [6:0]  lq_addr;
   logic        lq_done;
   logic [6:0]  lq_done_addr;
   logic [31:0] lq_done_dt;
   logic        hold;
   logic [95:0] rs_dt_o;
   logic        bubble_o;
   logic [7:0]  pend_cnt_o;
   logic        sb_err_o;
   logic        timeout_o;

   qcore_fwd_sb #(
      .NRD(3), .NSTG(3), .DW(32), .AW(7), .ZERO_REG(1'b1), .TMO_CYC(TMO)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .rs_vld_i(rs_vld), .rs_addr_i(rs_addr), .rs_dt_i(rs_dt),
      .stg_we_i(stg_we), .stg_addr_i(stg_addr), .stg_rdy_i(stg_rdy), .stg_dt_i(stg_dt),
      .lq_issue_i(lq_issue), .lq_addr_i(lq_addr),
      .lq_done_i(lq_done), .lq_done_addr_i(lq_done_addr), .lq_done_dt_i(lq_done_dt),
      .hold_i(hold),
      .rs_dt_o(rs_dt_o), .bubble_o(bubble_o), .pend_cnt_o(pend_cnt_o),
      .sb_err_o(sb_err_o), .timeout_o(timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed { int due; logic bub; } b_ent_t;
   typedef struct packed {
      int due; logic [95:0] dt; logic [2:0] known;
      logic [7:0] cnt; logic err; logic tmo;
   } o_ent_t;

   b_ent_t q_bub[$];
   o_ent_t q_out[$];

   int cyc = 0;
   int nvec = 0;
   int nerr = 0;

   // reference state
   logic [127:0] mp;
   logic [95:0]  mdt;
   logic [2:0]   mknown;
   logic         merr;
   logic         mtmo;
   int           mt;

   // {stall, value} for port p from the forwarding rules
   function automatic logic [32:0] mres(input int p);
      logic [6:0] a;
      a = rs_addr[p*7 +: 7];
      if (a == 7'd0) return {1'b0, 32'h0};
      if (lq_done && lq_done_addr == a) return {1'b0, lq_done_dt};
      if (mp[a]) return {1'b1, 32'h0};
      for (int s = 0; s < 3; s++)
         if (stg_we[s] && stg_addr[s*7 +: 7] == a)
            return stg_rdy[s] ? {1'b0, stg_dt[s*32 +: 32]} : {1'b1, 32'h0};
      return {1'b0, rs_dt[p*32 +: 32]};
   endfunction

   task automatic tick();
      logic [32:0] r [3];
      logic        bub;
      logic        iss_ok, done_ok;
      o_ent_t      oe;
      b_ent_t      be;
      #1;
      bub = 1'b0;
      for (int p = 0; p < 3; p++) begin
         r[p] = mres(p);
         if (rs_vld[p] && r[p][32]) bub = 1'b1;
      end
      be.due = cyc; be.bub = bub;
      q_bub.push_back(be);
      if (rst) begin
         mp = '0; mdt = '0; mknown = 3'b111; merr = 1'b0; mtmo = 1'b0; mt = 0;
      end else begin
         iss_ok  = lq_issue && lq_addr != 7'd0;
         done_ok = lq_done && lq_done_addr != 7'd0;
         if (iss_ok && mp[lq_addr]) merr = 1'b1;
         if (done_ok) mp[lq_done_addr] = 1'b0;
         if (iss_ok)  mp[lq_addr] = 1'b1;
         if (bub) begin
            if (mt < TMO) mt++;
            if (mt >= TMO) mtmo = 1'b1;
         end else mt = 0;
         if (!hold)
            for (int p = 0; p < 3; p++) begin
               mknown[p] = rs_vld[p] && !r[p][32];
               mdt[p*32 +: 32] = r[p][31:0];
            end
      end
      oe.due = cyc + 1; oe.dt = mdt; oe.known = mknown;
      oe.cnt = 8'($countones(mp)); oe.err = merr; oe.tmo = mtmo;
      q_out.push_back(oe);
      @(posedge clk);
      cyc++;
      #2;
   endtask

   // monitor: checks outputs away from the clock edge against queued expectations
   initial begin
      b_ent_t be;
      o_ent_t oe;
      forever begin
         @(negedge clk);
         while (q_bub.size() > 0 && q_bub[0].due == cyc) begin
            be = q_bub.pop_front();
            nvec++;
            if (bubble_o !== be.bub) begin
               nerr++;
               $display("FAIL bubble cyc=%0d got=%b exp=%b", cyc, bubble_o, be.bub);
            end
         end
         while (q_out.size() > 0 && q_out[0].due == cyc) begin
            oe = q_out.pop_front();
            for (int p = 0; p < 3; p++)
               if (oe.known[p]) begin
                  nvec++;
                  if (rs_dt_o[p*32 +: 32] !== oe.dt[p*32 +: 32]) begin
                     nerr++;
                     $display("FAIL rs_dt[%0d] cyc=%0d got=%h exp=%h", p, cyc,
                              rs_dt_o[p*32 +: 32], oe.dt[p*32 +: 32]);
                  end
               end
            nvec++;
            if (pend_cnt_o !== oe.cnt) begin
               nerr++;
               $display("FAIL pend_cnt cyc=%0d got=%0d exp=%0d", cyc, pend_cnt_o, oe.cnt);
            end
            nvec++;
            if (sb_err_o !== oe.err) begin
               nerr++;
               $display("FAIL sb_err cyc=%0d got=%b exp=%b", cyc, sb_err_o, oe.err);
            end
            nvec++;
            if (timeout_o !== oe.tmo) begin
               nerr++;
               $display("FAIL timeout cyc=%0d got=%b exp=%b", cyc, timeout_o, oe.tmo);
            end
         end
      end
   end

   task automatic clear_in();
      rs_vld = '0; rs_addr = '0; rs_dt = {$urandom, $urandom, $urandom};
      stg_we = '0; stg_addr = '0; stg_rdy = '0; stg_dt = {$urandom, $urandom, $urandom};
      lq_issue = 1'b0; lq_addr = '0; lq_done = 1'b0; lq_done_addr = '0;
      lq_done_dt = $urandom; hold = 1'b0;
   endtask

   task automatic set_port(input int p, input logic [6:0] a);
      rs_vld[p] = 1'b1;
      rs_addr[p*7 +: 7] = a;
   endtask

   task automatic set_stg(input int s, input logic [6:0] a, input logic rdy, input logic [31:0] d);
      stg_we[s] = 1'b1;
      stg_addr[s*7 +: 7] = a;
      stg_rdy[s] = rdy;
      stg_dt[s*32 +: 32] = d;
   endtask

   initial begin
      mp = '0; mdt = '0; mknown = 3'b111; merr = 1'b0; mtmo = 1'b0; mt = 0;
      rst = 1'b1;
      clear_in();
      @(posedge clk);
      #2;
      tick(); tick();
      rst = 1'b0;

      // two older stages match r5: stage1 wins
      clear_in(); set_port(0, 7'd5);
      set_stg(1, 7'd5, 1'b1, 32'hAA); set_stg(2, 7'd5, 1'b1, 32'hBB);
      tick(); clear_in(); tick();

      // youngest stage not ready, then ready
      set_port(1, 7'd9); set_stg(0, 7'd9, 1'b0, 32'h0); tick();
      set_stg(0, 7'd9, 1'b1, 32'h1234); tick();
      clear_in(); tick();

      // long-latency write with same-cycle completion bypass
      lq_issue = 1'b1; lq_addr = 7'd12; tick();
      lq_issue = 1'b0; set_port(2, 7'd12);
      repeat (4) tick();
      lq_done = 1'b1; lq_done_addr = 7'd12; lq_done_dt = 32'h55; tick();
      clear_in(); tick();

      // double issue and issue/done collision
      lq_issue = 1'b1; lq_addr = 7'd3; tick();
      tick();
      clear_in(); lq_issue = 1'b1; lq_addr = 7'd7; lq_done = 1'b1; lq_done_addr = 7'd7; tick();
      clear_in(); tick();

      // register zero and freeze
      set_port(0, 7'd0); set_stg(0, 7'd0, 1'b1, 32'hFF); tick();
      clear_in(); hold = 1'b1; set_port(0, 7'd20); set_port(1, 7'd21); tick(); tick();
      hold = 1'b0; tick();

      // timeout, then reset mid-stall and a stale completion
      rst = 1'b1; clear_in(); tick(); rst = 1'b0;
      lq_issue = 1'b1; lq_addr = 7'd4; tick();
      lq_issue = 1'b0; set_port(0, 7'd4);
      repeat (10) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      clear_in(); lq_done = 1'b1; lq_done_addr = 7'd4; tick();
      clear_in(); tick();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         rs_vld = 3'($urandom);
         for (int p = 0; p < 3; p++) rs_addr[p*7 +: 7] = 7'($urandom_range(0, 15));
         rs_dt = {$urandom, $urandom, $urandom};
         stg_we = 3'($urandom); stg_rdy = 3'($urandom);
         for (int s = 0; s < 3; s++) stg_addr[s*7 +: 7] = 7'($urandom_range(0, 15));
         stg_dt = {$urandom, $urandom, $urandom};
         lq_issue = ($urandom_range(0, 5) == 0);
         lq_addr = 7'($urandom_range(0, 15));
         lq_done = ($urandom_range(0, 3) == 0);
         lq_done_addr = 7'($urandom_range(0, 15));
         lq_done_dt = $urandom;
         hold = ($urandom_range(0, 4) == 0);
         rst = ($urandom_range(0, 79) == 0);
         tick();
      end
      rst = 1'b0; clear_in();

      @(negedge clk);
      #1;
      nvec++;
      if (q_bub.size() != 0 || q_out.size() != 0) begin
         nerr++;
         $display("FAIL drain got=%0d/%0d exp=0/0", q_bub.size(), q_out.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
